// File: rtl/multi_window_cycle_counter.sv
// Multi-channel cycle-window timer: per-channel level (high-time) or period (rise-to-rise)
// measurement of a synchronised flag, with saturating counters and sticky done/overflow status.
module multi_window_cycle_counter #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 33,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic                    en_i,
  input  logic [NUM_CH-1:0]       mode_i,
  input  logic [NUM_CH-1:0]       flag_i,
  input  logic [NUM_CH-1:0]       clr_i,
  input  logic [$clog2(NUM_CH):0] sel_i,
  output logic [CNT_W-1:0]        result_o,
  output logic [NUM_CH-1:0]       done_o,
  output logic [NUM_CH-1:0]       ovf_o,
  output logic [NUM_CH-1:0]       busy_o
);
  localparam int SEL_W    = $clog2(NUM_CH) + 1;
  localparam int NUM_SLOT = 1 << SEL_W;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE = 1'b0, MEAS = 1'b1} state_t;

  logic [NUM_CH-1:0] s;
  logic [NUM_CH-1:0] p_q;
  logic [NUM_CH-1:0] rise;
  logic [NUM_CH-1:0] fall;
  logic [CNT_W-1:0]  res_slot [NUM_SLOT];

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign s = flag_i;
    end else begin : g_sync
      logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
      always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
          for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
          sync_q[0] <= flag_i;
          for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
      end
      assign s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // p keeps tracking s even while disabled, so a flag already high at re-enable is not a rise.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) p_q <= '0;
    else          p_q <= s;
  end

  assign rise = s & ~p_q;
  assign fall = ~s & p_q;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    state_t           state_q, state_d;
    logic             mode_q, mode_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] res_q, res_d;
    logic             done_q, done_d;
    logic             ovf_q, ovf_d;
    logic             cnt_max;

    assign cnt_max = &cnt_q;

    always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
        state_q <= IDLE;
        mode_q  <= 1'b0;
        cnt_q   <= '0;
        res_q   <= '0;
        done_q  <= 1'b0;
        ovf_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        mode_q  <= mode_d;
        cnt_q   <= cnt_d;
        res_q   <= res_d;
        done_q  <= done_d;
        ovf_q   <= ovf_d;
      end
    end

    // Clear is applied first so that a same-cycle capture or saturation overrides it.
    always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      cnt_d   = cnt_q;
      res_d   = res_q;
      done_d  = done_q;
      ovf_d   = ovf_q;
      if (clr_i[c]) begin
        res_d  = '0;
        done_d = 1'b0;
        ovf_d  = 1'b0;
      end
      if (!en_i) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (rise[c]) begin
              mode_d  = mode_i[c];
              cnt_d   = CNT_ONE;
              state_d = MEAS;
            end
          end
          MEAS: begin
            if (!mode_q) begin
              if (fall[c]) begin
                res_d   = cnt_q;
                done_d  = 1'b1;
                state_d = IDLE;
              end else if (s[c]) begin
                if (cnt_max) ovf_d = 1'b1;
                else         cnt_d = cnt_q + CNT_ONE;
              end
            end else begin
              if (rise[c]) begin
                res_d  = cnt_q;
                done_d = 1'b1;
                cnt_d  = CNT_ONE;
              end else begin
                if (cnt_max) ovf_d = 1'b1;
                else         cnt_d = cnt_q + CNT_ONE;
              end
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end

    assign res_slot[c] = res_q;
    assign done_o[c]   = done_q;
    assign ovf_o[c]    = ovf_q;
    assign busy_o[c]   = (state_q == MEAS);
  end

  // Unused select codes read as zero.
  for (genvar c = NUM_CH; c < NUM_SLOT; c++) begin : g_pad
    assign res_slot[c] = '0;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) result_o <= '0;
    else          result_o <= res_slot[sel_i];
  end

endmodule

// File: tb/tb_multi_window_cycle_counter.sv
// Bench for multi_window_cycle_counter: directed scenarios plus a timestamp-based reference
// model compared against every output on every cycle.
module tb_multi_window_cycle_counter;
  localparam int NUM_CH      = 4;
  localparam int CNT_W       = 8;
  localparam int SYNC_STAGES = 2;
  localparam int MAX         = 255;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [3:0]       mode;
  logic [3:0]       flag;
  logic [3:0]       clr;
  logic [2:0]       sel;
  logic [CNT_W-1:0] result;
  logic [3:0]       done;
  logic [3:0]       ovf;
  logic [3:0]       busy;

  int checks   = 0;
  int failures = 0;

  multi_window_cycle_counter #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .en_i(en), .mode_i(mode), .flag_i(flag),
    .clr_i(clr), .sel_i(sel), .result_o(result), .done_o(done), .ovf_o(ovf), .busy_o(busy)
  );

  // clock / reset block
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: a measurement is a start timestamp; its length is elapsed edges, capped.
  logic [3:0] hist [$];
  int  cyc = 0;
  bit  model_ok = 1'b0;
  bit  m_act   [4];
  bit  m_mode  [4];
  int  m_start [4];
  int  m_res   [4];
  bit  m_done  [4];
  bit  m_ovf   [4];
  int  m_result;

  always @(posedge clk) begin
    logic [3:0] s_m;
    logic [3:0] p_m;
    int len;
    cyc++;
    if (rst) begin
      hist = {4'h0, 4'h0, 4'h0, 4'h0};
      for (int c = 0; c < 4; c++) begin
        m_act[c] = 0; m_mode[c] = 0; m_start[c] = 0;
        m_res[c] = 0; m_done[c] = 0; m_ovf[c] = 0;
      end
      m_result = 0;
      model_ok = 1'b1;
    end else if (model_ok) begin
      hist.push_back(flag);
      void'(hist.pop_front());
      s_m = hist[1];
      p_m = hist[0];
      m_result = (sel < 4) ? m_res[sel[1:0]] : 0;
      for (int c = 0; c < 4; c++) begin
        len = cyc - m_start[c];
        if (clr[c]) begin
          m_res[c] = 0; m_done[c] = 0; m_ovf[c] = 0;
        end
        if (!en) begin
          m_act[c] = 0;
        end else if (!m_act[c]) begin
          if (s_m[c] && !p_m[c]) begin
            m_act[c] = 1; m_mode[c] = mode[c]; m_start[c] = cyc;
          end
        end else if (!m_mode[c]) begin
          if (!s_m[c] && p_m[c]) begin
            m_res[c] = (len > MAX) ? MAX : len; m_done[c] = 1; m_act[c] = 0;
          end else if (len >= MAX) begin
            m_ovf[c] = 1;
          end
        end else begin
          if (s_m[c] && !p_m[c]) begin
            m_res[c] = (len > MAX) ? MAX : len; m_done[c] = 1; m_start[c] = cyc;
          end else if (len >= MAX) begin
            m_ovf[c] = 1;
          end
        end
      end
    end
  end

  // scoreboard compare, away from the active edge
  always @(negedge clk) begin
    logic [3:0] e_done;
    logic [3:0] e_ovf;
    logic [3:0] e_busy;
    if (model_ok) begin
      for (int c = 0; c < 4; c++) begin
        e_done[c] = m_done[c];
        e_ovf[c]  = m_ovf[c];
        e_busy[c] = m_act[c];
      end
      chk("model_result", result, m_result);
      chk("model_done", done, e_done);
      chk("model_ovf", ovf, e_ovf);
      chk("model_busy", busy, e_busy);
    end
  end

  initial begin
    rst = 1'b1; en = 1'b0; mode = 4'h0; flag = 4'h0; clr = 4'h0; sel = 3'd0;
    repeat (3) step();
    chk("reset_result", result, 0);
    chk("reset_done", done, 0);
    chk("reset_ovf", ovf, 0);
    chk("reset_busy", busy, 0);
    rst = 1'b0; en = 1'b1;

    // level ch0, 10-clock pulse
    flag[0] = 1'b1; repeat (10) step(); flag[0] = 1'b0;
    repeat (2) step(); chk("t1_done_latency", done[0], 0);
    step(); chk("t1_done", done[0], 1); chk("t1_busy", busy[0], 0);
    step(); chk("t1_result", result, 10); chk("t1_ovf", ovf[0], 0);

    // period ch1, rises 25 clocks apart
    mode[1] = 1'b1; sel = 3'd1;
    flag[1] = 1'b1; step(); step(); flag[1] = 1'b0; step();
    chk("t2_busy_start", busy[1], 1); chk("t2_no_done", done[1], 0);
    repeat (22) step();
    flag[1] = 1'b1; step(); step(); flag[1] = 1'b0; step();
    chk("t2_done", done[1], 1);
    step(); chk("t2_result", result, 25);
    repeat (21) step();
    flag[1] = 1'b1; step(); step(); flag[1] = 1'b0; step(); step();
    chk("t2_result_again", result, 25); chk("t2_busy", busy[1], 1);
    en = 1'b0; step(); chk("t2_stop", busy[1], 0); en = 1'b1;

    // saturation on ch2
    sel = 3'd2;
    flag[2] = 1'b1; repeat (300) step();
    chk("t3_ovf_mid", ovf[2], 1); chk("t3_no_done_mid", done[2], 0);
    flag[2] = 1'b0; repeat (3) step(); chk("t3_done", done[2], 1);
    step(); chk("t3_result", result, 255); chk("t3_ovf", ovf[2], 1);
    clr[2] = 1'b1; step(); clr[2] = 1'b0;
    chk("t3_clr_ovf", ovf[2], 0); chk("t3_clr_done", done[2], 0);

    // clear colliding with capture on ch3
    sel = 3'd3;
    flag[3] = 1'b1; repeat (7) step(); flag[3] = 1'b0;
    repeat (2) step(); clr[3] = 1'b1; step(); clr[3] = 1'b0;
    chk("t4_done", done[3], 1); chk("t4_ovf", ovf[3], 0);
    step(); chk("t4_result", result, 7);
    clr[3] = 1'b1; step(); clr[3] = 1'b0; chk("t4_clr_done", done[3], 0);
    step(); chk("t4_clr_result", result, 0);

    // enable dropped mid-pulse on ch0
    sel = 3'd0;
    clr[0] = 1'b1; step(); clr[0] = 1'b0;
    flag[0] = 1'b1; repeat (5) step(); chk("t5_busy_on", busy[0], 1);
    en = 1'b0; step(); chk("t5_busy_off", busy[0], 0);
    repeat (4) step(); en = 1'b1; repeat (10) step();
    chk("t5_no_restart", busy[0], 0);
    flag[0] = 1'b0; repeat (4) step();
    chk("t5_no_done", done[0], 0);
    flag[0] = 1'b1; repeat (4) step(); flag[0] = 1'b0;
    repeat (3) step(); chk("t5_done", done[0], 1);
    step(); chk("t5_result", result, 4);

    // reset mid-measure, flags held high across release
    flag = 4'hf; repeat (5) step(); chk("t6_all_busy", busy, 4'hf);
    rst = 1'b1; step(); rst = 1'b0;
    chk("t6_rst_result", result, 0); chk("t6_rst_done", done, 0);
    chk("t6_rst_ovf", ovf, 0); chk("t6_rst_busy", busy, 0);
    step(); step(); chk("t6_not_yet", busy, 0);
    step(); chk("t6_restart", busy, 4'hf);
    flag = 4'h0; repeat (6) step();
    sel = 3'd4; step(); step(); chk("t7_sel_out_of_range", result, 0);
    sel = 3'd0; step(); step(); chk("t7_sel0", result, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
